// File: rtl/feature_mem_writer_pkg.sv
// Shared definitions for the feature memory writer and reader counter.
// State encoding and default widths are common to both sides.
package feature_mem_writer_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;
    localparam int STATE_W        = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/feature_mem_writer.sv
// Streams words into the feature RAM at addresses 0..max_size.
// Optional checksum accumulator: FEATURE_WRITER_CHECKSUM_EN.
module feature_mem_writer
    import feature_mem_writer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] max_size,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_wr_en,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic                  o_busy,
`ifdef FEATURE_WRITER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] o_checksum,
`endif
    output logic                  o_done
);

    state_t state;
    state_t state_nx;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;

    logic xfer;
    logic start_acc;
    logic last_xfer;

    // o_ready depends on the state register only
    assign xfer      = (state == ST_WRITE) && i_valid;
    assign start_acc = (state == ST_IDLE) && start;
    assign last_xfer = xfer && (addr == last_addr);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state selection
    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_xfer) begin
                    state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        o_ready = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        unique case (state)
            ST_IDLE: begin
            end
            ST_WRITE: begin
                o_ready = 1'b1;
                o_busy  = 1'b1;
            end
            ST_DONE: begin
                o_done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Address counter and registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= '0;
            last_addr <= '0;
            o_wr_en   <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= xfer;
            if (start_acc) begin
                addr      <= '0;
                last_addr <= max_size;
            end
            if (xfer) begin
                o_wr_addr <= addr;
                o_wr_data <= i_data;
                // compare before increment: no wrap at full size
                if (!last_xfer) begin
                    addr <= addr + 1'b1;
                end
            end
        end
    end

`ifdef FEATURE_WRITER_CHECKSUM_EN
    // Modular sum of every word written in the burst
    always_ff @(posedge clk) begin
        if (reset) begin
            o_checksum <= '0;
        end else if (start_acc) begin
            o_checksum <= '0;
        end else if (xfer) begin
            o_checksum <= o_checksum + i_data;
        end
    end
`endif

endmodule

// File: tb/tb_feature_mem_writer.sv
// Self-checking bench for feature_mem_writer.
// Vector table plus model-checked directed and random traffic.
module tb_feature_mem_writer;

    localparam int DW = 8;
    localparam int AW = 12;

    logic          clk;
    logic          reset;
    logic          start;
    logic [AW-1:0] max_size;
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          o_wr_en;
    logic [AW-1:0] o_wr_addr;
    logic [DW-1:0] o_wr_data;
    logic          o_busy;
    logic          o_done;
`ifdef FEATURE_WRITER_CHECKSUM_EN
    logic [DW-1:0] o_checksum;
`endif

    feature_mem_writer #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .max_size  (max_size),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_wr_en   (o_wr_en),
        .o_wr_addr (o_wr_addr),
        .o_wr_data (o_wr_data),
        .o_busy    (o_busy),
`ifdef FEATURE_WRITER_CHECKSUM_EN
        .o_checksum(o_checksum),
`endif
        .o_done    (o_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks   = 0;
    int failures = 0;

    // behavioural model: burst = words still owed
    bit m_burst;
    bit m_done;
    int m_idx;
    int m_left;
    bit e_wr_en;
    int e_addr;
    int e_data;
    int e_chk;
    int dut_writes;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h",
                     nm, act, exp);
        end
    endtask

    task automatic model(input bit r, input bit s,
                         input int mx, input bit v,
                         input int d);
        bit fin;
        bit go;
        fin = 0;
        if (r) begin
            m_burst = 0;
            m_done  = 0;
            m_idx   = 0;
            m_left  = 0;
            e_wr_en = 0;
            e_addr  = 0;
            e_data  = 0;
            e_chk   = 0;
        end else begin
            e_wr_en = 0;
            go = !m_burst && !m_done && s;
            if (m_burst && v) begin
                e_wr_en = 1;
                e_addr  = m_idx;
                e_data  = d % 256;
                e_chk   = (e_chk + d) % 256;
                m_idx++;
                m_left--;
                fin = (m_left == 0);
            end
            m_done = fin;
            if (fin) m_burst = 0;
            if (go) begin
                m_burst = 1;
                m_idx   = 0;
                m_left  = (mx % 4096) + 1;
                e_chk   = 0;
            end
        end
    endtask

    task automatic tick(input bit r, input bit s,
                        input int mx, input bit v,
                        input int d);
        reset    = r;
        start    = s;
        max_size = AW'(mx);
        i_valid  = v;
        i_data   = DW'(d);
        model(r, s, mx, v, d);
        @(posedge clk);
        #1;
        if (o_wr_en === 1'b1) dut_writes++;
        chk("ready", 32'(o_ready), 32'(m_burst));
        chk("busy", 32'(o_busy), 32'(m_burst));
        chk("done", 32'(o_done), 32'(m_done));
        chk("wr_en", 32'(o_wr_en), 32'(e_wr_en));
        if (e_wr_en) begin
            chk("wr_addr", 32'(o_wr_addr), e_addr);
            chk("wr_data", 32'(o_wr_data), e_data);
        end
`ifdef FEATURE_WRITER_CHECKSUM_EN
        chk("checksum", 32'(o_checksum), e_chk);
`endif
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((m_burst || m_done) && n < budget) begin
            tick(0, 0, 0, 1, $urandom_range(0, 255));
            n++;
        end
        chk("drain_idle", 32'(o_busy | o_done), 0);
    endtask

    typedef struct {
        bit r;
        bit s;
        int mx;
        bit v;
        int d;
        bit er;
        bit ew;
        int ea;
        int ed;
        bit edn;
        bit eb;
    } vec_t;

    vec_t tv[7];
    int   w0;

    initial begin
        dut_writes = 0;
        tv[0] = '{0, 1, 3, 0, 8'h00, 1, 0, 0, 8'h00, 0, 1};
        tv[1] = '{0, 0, 3, 1, 8'h11, 1, 1, 0, 8'h11, 0, 1};
        tv[2] = '{0, 0, 3, 1, 8'h22, 1, 1, 1, 8'h22, 0, 1};
        tv[3] = '{0, 0, 3, 1, 8'h33, 1, 1, 2, 8'h33, 0, 1};
        tv[4] = '{0, 0, 3, 1, 8'h44, 0, 1, 3, 8'h44, 1, 0};
        tv[5] = '{0, 0, 3, 1, 8'h55, 0, 0, 0, 8'h00, 0, 0};
        tv[6] = '{0, 0, 3, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0};

        tick(1, 0, 0, 0, 0);
        tick(1, 1, 5, 1, 8'h77);
        chk("rst_ready", 32'(o_ready), 0);
        chk("rst_wr_en", 32'(o_wr_en), 0);
        chk("rst_wr_addr", 32'(o_wr_addr), 0);
        chk("rst_wr_data", 32'(o_wr_data), 0);
        chk("rst_busy", 32'(o_busy), 0);
        chk("rst_done", 32'(o_done), 0);
`ifdef FEATURE_WRITER_CHECKSUM_EN
        chk("rst_checksum", 32'(o_checksum), 0);
`endif

        // four-word burst from the vector table
        for (int i = 0; i < 7; i++) begin
            tick(tv[i].r, tv[i].s, tv[i].mx,
                 tv[i].v, tv[i].d);
            chk("tbl_ready", 32'(o_ready), 32'(tv[i].er));
            chk("tbl_wr_en", 32'(o_wr_en), 32'(tv[i].ew));
            chk("tbl_done", 32'(o_done), 32'(tv[i].edn));
            chk("tbl_busy", 32'(o_busy), 32'(tv[i].eb));
            if (tv[i].ew) begin
                chk("tbl_addr", 32'(o_wr_addr), tv[i].ea);
                chk("tbl_data", 32'(o_wr_data), tv[i].ed);
            end
        end

        // single word, extra word refused, start in DONE ignored
        w0 = dut_writes;
        tick(0, 1, 0, 0, 0);
        tick(0, 0, 0, 1, 8'hA5);
        chk("one_done", 32'(o_done), 1);
        chk("one_addr", 32'(o_wr_addr), 0);
        chk("one_data", 32'(o_wr_data), 8'hA5);
        tick(0, 1, 3, 1, 8'h5A);
        chk("one_ready_off", 32'(o_ready), 0);
        tick(0, 0, 0, 1, 8'h5A);
        chk("one_count", dut_writes - w0, 1);
        chk("one_idle", 32'(o_busy), 0);

        // six words with i_valid toggling
        w0 = dut_writes;
        tick(0, 1, 5, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick(0, 0, 0, i % 2, $urandom_range(0, 255));
        end
        chk("tog_done", 32'(o_done), 1);
        chk("tog_last", 32'(o_wr_addr), 5);
        tick(0, 0, 0, 0, 0);
        chk("tog_count", dut_writes - w0, 6);

        // reset after two of eight words
        w0 = dut_writes;
        tick(0, 1, 7, 0, 0);
        tick(0, 0, 0, 1, 8'h01);
        tick(0, 0, 0, 1, 8'h02);
        tick(1, 0, 0, 1, 8'h03);
        chk("abort_wr_en", 32'(o_wr_en), 0);
        chk("abort_addr", 32'(o_wr_addr), 0);
        chk("abort_data", 32'(o_wr_data), 0);
        chk("abort_ready", 32'(o_ready), 0);
        for (int i = 0; i < 6; i++) begin
            tick(0, 0, 0, 1, 8'h04);
            chk("abort_no_done", 32'(o_done), 0);
        end
        chk("abort_count", dut_writes - w0, 2);
        tick(0, 1, 2, 0, 0);
        tick(0, 0, 0, 1, 8'h9C);
        chk("restart_addr", 32'(o_wr_addr), 0);
        chk("restart_data", 32'(o_wr_data), 8'h9C);
        drain(10);

        // restart mid-burst is ignored
        w0 = dut_writes;
        tick(0, 1, 4, 0, 0);
        tick(0, 0, 0, 1, 8'h10);
        tick(0, 1, 1, 1, 8'h20);
        tick(0, 1, 9, 1, 8'h30);
        chk("mid_busy", 32'(o_busy), 1);
        tick(0, 0, 0, 1, 8'h40);
        tick(0, 0, 0, 1, 8'h50);
        chk("mid_done", 32'(o_done), 1);
        chk("mid_last", 32'(o_wr_addr), 4);
        tick(0, 0, 0, 1, 0);
        chk("mid_count", dut_writes - w0, 5);

`ifdef FEATURE_WRITER_CHECKSUM_EN
        tick(0, 1, 1, 0, 0);
        tick(0, 0, 0, 1, 8'hF0);
        tick(0, 0, 0, 1, 8'h20);
        chk("csum_done", 32'(o_done), 1);
        chk("csum_value", 32'(o_checksum), 8'h10);
        tick(0, 0, 0, 1, 8'h33);
        chk("csum_hold", 32'(o_checksum), 8'h10);
`endif

        // full memory sweep without wrap
        w0 = dut_writes;
        tick(0, 1, 4095, 0, 0);
        for (int i = 0; i < 4096; i++) begin
            tick(0, 0, 0, 1, $urandom_range(0, 255));
        end
        chk("full_done", 32'(o_done), 1);
        chk("full_last", 32'(o_wr_addr), 4095);
        tick(0, 0, 0, 1, 0);
        chk("full_count", dut_writes - w0, 4096);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            tick($urandom_range(0, 59) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 6),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 255));
        end
        drain(20);

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
